text_cursor_writer: RTL

- Upstream feeder for the character plane (15 rows x 40 cols of 8-bit character ids).
- Consumes a byte stream, for example from a UART receiver, using a valid/ready handshake.
- Maintains a text cursor and interprets a small set of control codes.
- Emits one registered single-cell write command per cycle into the character plane's write port. This includes bulk clears: the whole screen at reset or form-feed, and a single line on row advance.

---
 rtl/text_cursor_writer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/text_cursor_writer.sv
// Byte-stream text cursor for a ROW_NUMBER x COL_NUMBER character plane.
// Issues one registered cell write per cycle, including full-screen and single-line clears.
module text_cursor_writer #(
    parameter int ROW_NUMBER     = 15,
    parameter int COL_NUMBER     = 40,
    parameter int ROW_BIT_LEN    = 4,
    parameter int COL_BIT_LEN    = 6,
    parameter int CHAR_ID_LENGTH = 8,
    parameter logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHAR_ID_LENGTH-1:0] rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic                      wr_en,
    output logic [ROW_BIT_LEN-1:0]    wr_row,
    output logic [COL_BIT_LEN-1:0]    wr_col,
    output logic [CHAR_ID_LENGTH-1:0] wr_char,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    localparam logic [ROW_BIT_LEN-1:0]    ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0]    COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
    localparam logic [ROW_BIT_LEN-1:0]    ROW_ZERO = ROW_BIT_LEN'(0);
    localparam logic [COL_BIT_LEN-1:0]    COL_ZERO = COL_BIT_LEN'(0);
    localparam logic [ROW_BIT_LEN-1:0]    ROW_ONE  = ROW_BIT_LEN'(1);
    localparam logic [COL_BIT_LEN-1:0]    COL_ONE  = COL_BIT_LEN'(1);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_LF    = CHAR_ID_LENGTH'(8'h0A);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_FF    = CHAR_ID_LENGTH'(8'h0C);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_CR    = CHAR_ID_LENGTH'(8'h0D);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_SPACE = CHAR_ID_LENGTH'(8'h20);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_TILDE = CHAR_ID_LENGTH'(8'h7E);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_HIGH  = CHAR_ID_LENGTH'(8'h80);

    state_t                      state_q, state_d;
    logic [ROW_BIT_LEN-1:0]      cur_row_q, cur_row_d;
    logic [COL_BIT_LEN-1:0]      cur_col_q, cur_col_d;
    logic [ROW_BIT_LEN-1:0]      clr_row_q, clr_row_d;
    logic [COL_BIT_LEN-1:0]      clr_col_q, clr_col_d;
    logic                        wr_en_q, wr_en_d;
    logic [ROW_BIT_LEN-1:0]      wr_row_q, wr_row_d;
    logic [COL_BIT_LEN-1:0]      wr_col_q, wr_col_d;
    logic [CHAR_ID_LENGTH-1:0]   wr_char_q, wr_char_d;
    logic                        busy_q, busy_d;

    function automatic logic is_printable(input logic [CHAR_ID_LENGTH-1:0] b);
        return ((b >= CH_SPACE) && (b <= CH_TILDE)) || (b >= CH_HIGH);
    endfunction

    function automatic logic [ROW_BIT_LEN-1:0] next_row(input logic [ROW_BIT_LEN-1:0] r);
        return (r == ROW_LAST) ? ROW_ZERO : (r + ROW_ONE);
    endfunction

    assign rx_ready   = (state_q == IDLE);
    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign wr_char    = wr_char_q;
    assign cursor_row = cur_row_q;
    assign cursor_col = cur_col_q;
    assign busy       = busy_q;

    // Next-state, cursor, clear-scan and write-command decode.
    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_char_d = wr_char_q;

        case (state_q)
            CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_row_d  = clr_row_q;
                wr_col_d  = clr_col_q;
                wr_char_d = BLANK_CHAR;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = COL_ZERO;
                    if (clr_row_q == ROW_LAST) begin
                        clr_row_d = ROW_ZERO;
                        cur_row_d = ROW_ZERO;
                        cur_col_d = COL_ZERO;
                        state_d   = IDLE;
                    end else begin
                        clr_row_d = clr_row_q + ROW_ONE;
                    end
                end else begin
                    clr_col_d = clr_col_q + COL_ONE;
                end
            end
            CLR_LINE: begin
                wr_en_d   = 1'b1;
                wr_row_d  = cur_row_q;
                wr_col_d  = clr_col_q;
                wr_char_d = BLANK_CHAR;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = COL_ZERO;
                    state_d   = IDLE;
                end else begin
                    clr_col_d = clr_col_q + COL_ONE;
                end
            end
            IDLE: begin
                if (rx_valid && rx_ready) begin
                    if (is_printable(rx_data)) begin
                        wr_en_d   = 1'b1;
                        wr_row_d  = cur_row_q;
                        wr_col_d  = cur_col_q;
                        wr_char_d = rx_data;
                        // Writing the last column wraps and clears the next line.
                        if (cur_col_q == COL_LAST) begin
                            cur_col_d = COL_ZERO;
                            cur_row_d = next_row(cur_row_q);
                            clr_col_d = COL_ZERO;
                            state_d   = CLR_LINE;
                        end else begin
                            cur_col_d = cur_col_q + COL_ONE;
                        end
                    end else begin
                        case (rx_data)
                            CH_CR: cur_col_d = COL_ZERO;
                            CH_LF: begin
                                cur_col_d = COL_ZERO;
                                cur_row_d = next_row(cur_row_q);
                                clr_col_d = COL_ZERO;
                                state_d   = CLR_LINE;
                            end
                            CH_BS: begin
                                if (cur_col_q != COL_ZERO) begin
                                    cur_col_d = cur_col_q - COL_ONE;
                                    wr_en_d   = 1'b1;
                                    wr_row_d  = cur_row_q;
                                    wr_col_d  = cur_col_q - COL_ONE;
                                    wr_char_d = BLANK_CHAR;
                                end else begin
                                    cur_col_d = cur_col_q;
                                end
                            end
                            CH_FF: begin
                                clr_row_d = ROW_ZERO;
                                clr_col_d = COL_ZERO;
                                state_d   = CLR_ALL;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                clr_row_d = ROW_ZERO;
                clr_col_d = COL_ZERO;
                state_d   = CLR_ALL;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered output flops; reset restarts the full-screen clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLR_ALL;
            cur_row_q <= ROW_ZERO;
            cur_col_q <= COL_ZERO;
            clr_row_q <= ROW_ZERO;
            clr_col_q <= COL_ZERO;
            wr_en_q   <= 1'b0;
            wr_row_q  <= ROW_ZERO;
            wr_col_q  <= COL_ZERO;
            wr_char_q <= {CHAR_ID_LENGTH{1'b0}};
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_char_q <= wr_char_d;
            busy_q    <= busy_d;
        end
    end

endmodule
